// File: rtl/route_stream_out.sv
// Burst reader for the route write FIFO: waits for a full burst, then streams
// it out through a 2-entry skid buffer as an AXI-Stream master with tlast/done.
module route_stream_out #(
    parameter int WIDTH     = 128,
    parameter int ADDR_BITS = 10,
    parameter int LEN_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_BITS-1:0]  total_beats,
    input  logic [ADDR_BITS:0]   burst_len,
    output logic [ADDR_BITS:0]   M_count,
    input  logic                 M_Ready,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 fifo_empty,
    output logic [WIDTH-1:0]     m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = ADDR_BITS + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WAIT,
        BURST,
        DRAIN,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic [LEN_BITS-1:0] total_q;
    logic [LEN_BITS-1:0] remaining;
    logic [LEN_BITS-1:0] sent;
    logic [CW-1:0]       blen_q;
    logic [CW-1:0]       burst_left;
    logic [CW-1:0]       m_count_q;
    logic                settle_q;
    logic                inflight;
    logic [1:0]          buf_count;
    logic [WIDTH-1:0]    buf0;
    logic [WIDTH-1:0]    buf1;

    logic                accept;
    logic                rd;
    logic [2:0]          occ;
    logic [1:0]          slot;
    logic [CW-1:0]       next_mcount;

    assign m_axis_tvalid = (buf_count != 2'd0);
    assign m_axis_tdata  = buf0;
    assign m_axis_tlast  = m_axis_tvalid && (sent == total_q - LEN_BITS'(1));
    assign accept        = m_axis_tvalid && m_axis_tready;
    assign M_count       = m_count_q;

    // A beat leaving this cycle frees its slot, which keeps one read per cycle.
    assign occ  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, accept};
    assign slot = buf_count - {1'b0, accept};

    assign rd = (state == BURST) && (burst_left != '0) && !fifo_empty
                && (occ < 3'd2);
    assign fifo_rd_en = rd;

    assign next_mcount = (LEN_BITS'(blen_q) <= remaining) ? blen_q
                                                          : CW'(remaining);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = (total_beats == '0) ? FIN : SETTLE;
            end
            SETTLE: begin
                if (settle_q) state_nxt = WAIT;
            end
            WAIT: begin
                if (M_Ready) state_nxt = BURST;
            end
            BURST: begin
                if (burst_left == '0)
                    state_nxt = (remaining != '0) ? SETTLE : DRAIN;
            end
            DRAIN: begin
                if (buf_count == 2'd0 && !inflight) state_nxt = FIN;
            end
            FIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q    <= '0;
            remaining  <= '0;
            sent       <= '0;
            blen_q     <= '0;
            burst_left <= '0;
            m_count_q  <= '0;
            settle_q   <= 1'b0;
            inflight   <= 1'b0;
            buf_count  <= 2'd0;
            buf0       <= '0;
            buf1       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= rd;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        total_q   <= total_beats;
                        blen_q    <= (burst_len == '0) ? CW'(1) : burst_len;
                        remaining <= total_beats;
                        sent      <= '0;
                        busy      <= 1'b1;
                    end
                end
                SETTLE: begin
                    // M_Ready is registered in the FIFO, so hold one extra cycle
                    m_count_q <= next_mcount;
                    settle_q  <= ~settle_q;
                end
                WAIT: begin
                    if (M_Ready) burst_left <= m_count_q;
                end
                BURST: begin
                    if (rd) begin
                        burst_left <= burst_left - CW'(1);
                        remaining  <= remaining - LEN_BITS'(1);
                    end
                end
                FIN: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    m_count_q <= '0;
                end
                default: ;
            endcase

            if (accept) begin
                sent <= sent + LEN_BITS'(1);
                buf0 <= buf1;
            end
            if (inflight) begin
                if (slot == 2'd0) buf0 <= fifo_dout;
                else              buf1 <= fifo_dout;
            end
            buf_count <= buf_count + {1'b0, inflight} - {1'b0, accept};
        end
    end

endmodule

// File: tb/tb_route_stream_out.sv
// Randomized bench for route_stream_out with a FIFO model and a beat
// scoreboard derived from the transfer/burst arithmetic.
module tb_route_stream_out;

    localparam int W  = 128;
    localparam int AB = 10;
    localparam int LB = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [LB-1:0]   total_beats = '0;
    logic [AB:0]     burst_len = '0;
    logic [AB:0]     M_count;
    logic            M_Ready = 1'b0;
    logic            fifo_rd_en;
    logic [W-1:0]    fifo_dout = '0;
    logic            fifo_empty = 1'b1;
    logic [W-1:0]    m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast;
    logic            busy;
    logic            done;

    route_stream_out #(.WIDTH(W), .ADDR_BITS(AB), .LEN_BITS(LB)) dut (
        .clk(clk), .rst(rst), .start(start),
        .total_beats(total_beats), .burst_len(burst_len),
        .M_count(M_count), .M_Ready(M_Ready),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nbad = 0;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] pend[$];
    logic [W-1:0] exp_q[$];
    bit           feed_en = 1'b1;
    bit           force_rdy = 1'b0;

    // FIFO model: registered read data, registered empty and threshold flag
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0)
            fifo_dout <= fifo_q.pop_front();
        if (feed_en && pend.size() > 0 && $urandom_range(0, 2) != 0)
            fifo_q.push_back(pend.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
        M_Ready    <= force_rdy || (fifo_q.size() >= int'(M_count));
    end

    int tr_mode = 0;
    int pidx = 0;

    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = 1'($urandom_range(0, 1));
            2: begin
                m_axis_tready = (pidx == 0 || pidx == 3);
                pidx = (pidx + 1) % 4;
            end
            default: m_axis_tready = 1'b0;
        endcase
    end

    int cur_total = 0;
    int cur_bl = 1;
    int reads = 0;
    int beats = 0;
    int outst = 0;
    int valid_cyc = 0;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic prev_last;

    function automatic int burst_size(input int r);
        int b;
        int rest;
        b    = r / cur_bl;
        rest = cur_total - b * cur_bl;
        return (rest < cur_bl) ? rest : cur_bl;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            outst      = 0;
            prev_stall = 1'b0;
        end else begin
            if (m_axis_tvalid) valid_cyc++;
            if (prev_stall) begin
                check("stall_valid", m_axis_tvalid, 1);
                check("stall_data", m_axis_tdata, prev_data);
                check("stall_last", m_axis_tlast, prev_last);
            end
            if (fifo_rd_en) begin
                check("rd_empty", fifo_empty, 0);
                check("mcount", M_count, burst_size(reads));
                reads++;
                outst++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check("tdata", m_axis_tdata, exp_q.pop_front());
                check("tlast", m_axis_tlast, beats == cur_total - 1);
                beats++;
                outst--;
            end
            if (fifo_rd_en) check("occupancy", outst <= 2, 1);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_xfer(input int tot, input int bl, input int pre,
                            input int gap, input bit stray);
        logic [W-1:0] w;
        int n;
        for (int i = 0; i < tot; i++) begin
            w = rand_word();
            exp_q.push_back(w);
            if (i < pre) fifo_q.push_back(w);
            else         pend.push_back(w);
        end
        feed_en = (gap == 0);
        repeat (2) @(negedge clk);
        cur_total   = tot;
        cur_bl      = (bl == 0) ? 1 : bl;
        reads       = 0;
        beats       = 0;
        valid_cyc   = 0;
        total_beats = LB'(tot);
        burst_len   = (AB + 1)'(bl);
        start       = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = stray && (n == 5);
            if (stray && n == 5) total_beats = LB'(3);
            if (n == 1) check("busy_start", busy, 1);
            if (gap > 0 && n == gap - 1) begin
                check("gap_reads", reads, pre);
                check("gap_mcount", M_count, burst_size(pre));
            end
            if (gap > 0 && n == gap) feed_en = 1'b1;
        end while (!done && n < 4000);
        check("done_seen", done, 1);
        check("busy_done", busy, 0);
        if (tot == 0) begin
            check("zero_latency", n, 2);
            check("zero_reads", reads, 0);
            check("zero_valid", valid_cyc, 0);
        end else begin
            check("beats", beats, tot);
            check("reads", reads, tot);
        end
        check("exp_left", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        feed_en = 1'b1;
    endtask

    initial begin
        int tot;
        int bl;
        int n;
        logic [W-1:0] w;

        repeat (3) @(negedge clk);
        check("rst_mcount", M_count, 0);
        check("rst_rd", fifo_rd_en, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        tr_mode = 0;
        run_xfer(8, 4, 8, 0, 1'b0);
        run_xfer(10, 4, 8, 40, 1'b1);
        tr_mode = 2;
        run_xfer(16, 16, 16, 0, 1'b0);
        tr_mode = 0;
        run_xfer(0, 4, 0, 0, 1'b0);
        force_rdy = 1'b1;
        run_xfer(6, 6, 3, 20, 1'b0);
        force_rdy = 1'b0;

        // reset with beats sitting in the skid buffer
        tr_mode = 3;
        for (int i = 0; i < 8; i++) begin
            w = rand_word();
            exp_q.push_back(w);
            fifo_q.push_back(w);
        end
        repeat (2) @(negedge clk);
        cur_total   = 8;
        cur_bl      = 4;
        reads       = 0;
        beats       = 0;
        total_beats = LB'(8);
        burst_len   = (AB + 1)'(4);
        start       = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!m_axis_tvalid && n < 60);
        check("rst_setup_valid", m_axis_tvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_mcount", M_count, 0);
        fifo_q.delete();
        pend.delete();
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        tr_mode = 1;
        run_xfer(4, 4, 4, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            tr_mode = $urandom_range(0, 2);
            tot = $urandom_range(1, 40);
            bl  = $urandom_range(0, 9);
            run_xfer(tot, bl, ($urandom_range(0, 1) != 0) ? tot : 0, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
